// File: rtl/epsilon_sched_if.sv
// Requester-side bundle of the epsilon scheduler.
// Level requests in, one-hot sample strobe plus shared data out.
interface epsilon_sched_if #(
    parameter int NUM_REQ = 4,
    parameter int EPS_W   = 21
);
    logic [NUM_REQ-1:0] req;
    logic [NUM_REQ-1:0] eps_valid;
    logic [EPS_W-1:0]   eps_data;
    logic               ready;

    modport master (
        input  req,
        output eps_valid,
        output eps_data,
        output ready
    );

    modport slave (
        output req,
        input  eps_valid,
        input  eps_data,
        input  ready
    );
endinterface

// File: rtl/epsilon_sched.sv
// Owns the shared epsilon PRNG: seed/warm-up sequencing, round-robin
// sharing among requesters and periodic stepped reseeding.
module epsilon_sched #(
    parameter int         NUM_REQ       = 4,
    parameter int         EPS_W         = 21,
    parameter int         WARMUP        = 3,
    parameter int         RESEED_PERIOD = 64,
    parameter logic [4:0] SEED_STEP     = 5'd7
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             start,
    input  logic             reseed,
    input  logic [4:0]       seed_in,
    epsilon_sched_if.master  bus,
    output logic             prng_rst,
    output logic [4:0]       prng_seed,
    input  logic [EPS_W-1:0] prng_rand,
    output logic [7:0]       reseed_cnt
);
    localparam int PW = $clog2(NUM_REQ);
    localparam int CW = 16;

    typedef enum logic [1:0] {
        IDLE,
        LOAD,
        WARM,
        SERVE
    } state_t;

    state_t             state_q, state_d;
    logic [4:0]         seed_q, seed_d;
    logic [CW-1:0]      cnt_q, cnt_d;
    logic [7:0]         rcnt_q, rcnt_d;
    logic [3:0]         warm_q, warm_d;
    logic [PW-1:0]      ptr_q, ptr_d;
    logic [PW-1:0]      win, idx;
    logic [NUM_REQ-1:0] valid_q, valid_d, elig;
    logic [EPS_W-1:0]   data_q, data_d;
    logic               grant, hit, prst_d;

    always_comb begin
        // a requester strobed this cycle sits out one round
        elig  = bus.req & ~valid_q;
        grant = 1'b0;
        win   = '0;
        idx   = '0;
        for (int i = 0; i < NUM_REQ; i++) begin
            idx = PW'((int'(ptr_q) + i) % NUM_REQ);
            if (!grant && elig[idx]) begin
                grant = 1'b1;
                win   = idx;
            end
        end
        if (state_q != SERVE) grant = 1'b0;
        hit = grant && (RESEED_PERIOD != 0)
            && (int'(cnt_q) == RESEED_PERIOD - 1);

        state_d = state_q;
        seed_d  = seed_q;
        cnt_d   = cnt_q;
        rcnt_d  = rcnt_q;
        warm_d  = warm_q;
        ptr_d   = ptr_q;
        valid_d = '0;
        data_d  = data_q;

        if (grant) begin
            valid_d[win] = 1'b1;
            data_d       = prng_rand;
            ptr_d        = PW'((int'(win) + 1) % NUM_REQ);
            cnt_d        = cnt_q + 1'b1;
        end

        unique case (state_q)
            IDLE: ;
            LOAD: begin
                state_d = WARM;
                warm_d  = '0;
            end
            WARM: begin
                if (warm_q == 4'(WARMUP - 1)) state_d = SERVE;
                else warm_d = warm_q + 1'b1;
            end
            SERVE: begin
                if (hit || reseed) begin
                    seed_d  = seed_q + SEED_STEP;
                    cnt_d   = '0;
                    rcnt_d  = rcnt_q + 1'b1;
                    state_d = LOAD;
                end
            end
            default: ;
        endcase

        // an explicit start overrides any pending reseed
        if (start) begin
            seed_d  = seed_in;
            cnt_d   = '0;
            rcnt_d  = rcnt_q;
            state_d = LOAD;
        end

        prst_d = (state_d == IDLE) || (state_d == LOAD);
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_q  <= IDLE;
            seed_q   <= '0;
            cnt_q    <= '0;
            rcnt_q   <= '0;
            warm_q   <= '0;
            ptr_q    <= '0;
            valid_q  <= '0;
            data_q   <= '0;
            prng_rst <= 1'b1;
        end else begin
            state_q  <= state_d;
            seed_q   <= seed_d;
            cnt_q    <= cnt_d;
            rcnt_q   <= rcnt_d;
            warm_q   <= warm_d;
            ptr_q    <= ptr_d;
            valid_q  <= valid_d;
            data_q   <= data_d;
            prng_rst <= prst_d;
        end
    end

    assign bus.eps_valid = valid_q;
    assign bus.eps_data  = data_q;
    assign bus.ready     = (state_q == SERVE);
    assign prng_seed     = seed_q;
    assign reseed_cnt    = rcnt_q;
endmodule

// File: tb/tb_epsilon_sched.sv
// Randomised bench for epsilon_sched against a cycle-level behavioural
// model, plus directed sequences with hand-computed expectations.
module tb_epsilon_sched;
    localparam int         N    = 4;
    localparam int         EW   = 21;
    localparam int         WU   = 3;
    localparam int         RP   = 4;
    localparam logic [4:0] STEP = 5'd7;

    logic          clk = 1'b0;
    logic          rst = 1'b0;
    logic          start = 1'b0;
    logic          reseed = 1'b0;
    logic [4:0]    seed_in = '0;
    logic          prng_rst;
    logic [4:0]    prng_seed;
    logic [EW-1:0] prng_rand = '0;
    logic [EW-1:0] last_rand = '0;
    logic [7:0]    reseed_cnt;

    int checks = 0;
    int errors = 0;

    epsilon_sched_if #(.NUM_REQ(N), .EPS_W(EW)) bus ();

    epsilon_sched #(
        .NUM_REQ      (N),
        .EPS_W        (EW),
        .WARMUP       (WU),
        .RESEED_PERIOD(RP),
        .SEED_STEP    (STEP)
    ) dut (
        .clk       (clk),
        .rst       (rst),
        .start     (start),
        .reseed    (reseed),
        .seed_in   (seed_in),
        .bus       (bus),
        .prng_rst  (prng_rst),
        .prng_seed (prng_seed),
        .prng_rand (prng_rand),
        .reseed_cnt(reseed_cnt)
    );

    always #5 clk = ~clk;

    task automatic chk(input string name, input logic [31:0] act,
                       input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h at %0t",
                     name, act, exp, $time);
        end
    endtask

    // model: phase 0 idle, 1 = m_wait cycles until serving, 2 serving
    int            m_phase = 0;
    int            m_wait = 0;
    int            m_samples = 0;
    int            m_ptr = 0;
    int            m_win;
    logic [4:0]    m_seed = '0;
    logic [7:0]    m_rcnt = '0;
    logic [N-1:0]  m_valid = '0;
    logic [N-1:0]  m_nv;
    logic [EW-1:0] m_data = '0;
    bit            m_hit;

    always @(posedge clk or negedge rst) begin
        if (!rst) begin
            m_phase = 0; m_wait = 0; m_samples = 0; m_ptr = 0;
            m_seed = '0; m_rcnt = '0; m_valid = '0; m_data = '0;
        end else begin
            m_nv  = '0;
            m_hit = 0;
            m_win = -1;
            if (m_phase == 2) begin
                for (int k = 0; k < N; k++)
                    if (m_win < 0 && bus.req[(m_ptr + k) % N]
                        && !m_valid[(m_ptr + k) % N])
                        m_win = (m_ptr + k) % N;
                if (m_win >= 0) begin
                    m_nv[m_win] = 1'b1;
                    m_data = prng_rand;
                    m_ptr = (m_win + 1) % N;
                    m_samples++;
                    m_hit = (RP != 0) && (m_samples == RP);
                end
            end
            if (start) begin
                m_seed = seed_in; m_samples = 0;
                m_phase = 1; m_wait = 1 + WU;
            end else if (m_phase == 2 && (reseed || m_hit)) begin
                m_seed = m_seed + STEP; m_samples = 0;
                m_rcnt = m_rcnt + 8'd1;
                m_phase = 1; m_wait = 1 + WU;
            end else if (m_phase == 1) begin
                m_wait--;
                if (m_wait == 0) m_phase = 2;
            end
            m_valid = m_nv;
        end
    end

    always @(negedge clk) begin
        chk("eps_valid", 32'(bus.eps_valid), 32'(m_valid));
        chk("eps_data", 32'(bus.eps_data), 32'(m_data));
        chk("ready", 32'(bus.ready), 32'(m_phase == 2));
        chk("prng_rst", 32'(prng_rst),
            32'(m_phase == 0 || (m_phase == 1 && m_wait == 1 + WU)));
        chk("prng_seed", 32'(prng_seed), 32'(m_seed));
        chk("reseed_cnt", 32'(reseed_cnt), 32'(m_rcnt));
    end

    task automatic cyc();
        @(posedge clk);
        #2;
        last_rand = prng_rand;
        prng_rand = EW'($urandom);
    endtask

    task automatic wait_ready();
        for (int i = 0; i < 50 && !bus.ready; i++) cyc();
        chk("wait_ready", 32'(bus.ready), 32'd1);
    endtask

    initial begin
        #2_000_000;
        errors++;
        $display("FAIL watchdog: got timeout, expected completion");
        $display("Simulation finished: %0d checks, %0d errors",
                 checks, errors);
        $fatal(1, "watchdog");
    end

    initial begin
        bus.req = '0;
        repeat (3) @(posedge clk);
        #2;
        chk("rst_prng_rst", 32'(prng_rst), 32'd1);
        chk("rst_ready", 32'(bus.ready), 32'd0);
        chk("rst_valid", 32'(bus.eps_valid), 32'd0);
        chk("rst_seed", 32'(prng_seed), 32'd0);
        chk("rst_rcnt", 32'(reseed_cnt), 32'd0);
        rst = 1'b1;
        cyc();
        chk("idle_prng_rst", 32'(prng_rst), 32'd1);

        start = 1'b1; seed_in = 5'd3;
        cyc();
        start = 1'b0;
        chk("load_prng_rst", 32'(prng_rst), 32'd1);
        chk("load_seed", 32'(prng_seed), 32'd3);
        chk("load_ready", 32'(bus.ready), 32'd0);
        cyc();
        chk("warm_prng_rst", 32'(prng_rst), 32'd0);
        chk("warm_ready", 32'(bus.ready), 32'd0);
        cyc(); cyc();
        chk("warm3_ready", 32'(bus.ready), 32'd0);
        cyc();
        chk("serve_ready", 32'(bus.ready), 32'd1);

        bus.req = 4'hF;
        for (int i = 0; i < 4; i++) begin
            cyc();
            chk("rr_valid", 32'(bus.eps_valid), 32'd1 << i);
            chk("rr_data", 32'(bus.eps_data), 32'(last_rand));
        end
        chk("auto_seed", 32'(prng_seed), 32'd10);
        chk("auto_rcnt", 32'(reseed_cnt), 32'd1);
        chk("auto_ready", 32'(bus.ready), 32'd0);
        chk("auto_prng_rst", 32'(prng_rst), 32'd1);
        for (int i = 0; i < WU; i++) begin
            cyc();
            chk("rewarm_ready", 32'(bus.ready), 32'd0);
        end
        cyc();
        chk("reserve_ready", 32'(bus.ready), 32'd1);

        bus.req = 4'b0100;
        cyc();
        chk("solo_valid0", 32'(bus.eps_valid), 32'h4);
        cyc();
        chk("solo_valid1", 32'(bus.eps_valid), 32'h0);
        cyc();
        chk("solo_valid2", 32'(bus.eps_valid), 32'h4);
        bus.req = '0;

        start = 1'b1; seed_in = 5'd21;
        cyc();
        start = 1'b0;
        wait_ready();
        reseed = 1'b1;
        cyc();
        reseed = 1'b0;
        chk("step_seed", 32'(prng_seed), 32'd28);
        chk("step_rcnt", 32'(reseed_cnt), 32'd2);
        wait_ready();
        reseed = 1'b1;
        cyc();
        reseed = 1'b0;
        chk("wrap_seed", 32'(prng_seed), 32'd3);
        chk("wrap_rcnt", 32'(reseed_cnt), 32'd3);
        wait_ready();
        reseed = 1'b1; start = 1'b1; seed_in = 5'd9;
        cyc();
        reseed = 1'b0; start = 1'b0;
        chk("prio_seed", 32'(prng_seed), 32'd9);
        chk("prio_rcnt", 32'(reseed_cnt), 32'd3);

        wait_ready();
        bus.req = 4'b0010;
        #1 rst = 1'b0;
        #1;
        chk("arst_valid", 32'(bus.eps_valid), 32'd0);
        chk("arst_prng_rst", 32'(prng_rst), 32'd1);
        chk("arst_ready", 32'(bus.ready), 32'd0);
        cyc(); cyc();
        rst = 1'b1;
        repeat (3) cyc();
        chk("idle_hold_ready", 32'(bus.ready), 32'd0);
        chk("idle_hold_valid", 32'(bus.eps_valid), 32'd0);
        chk("idle_hold_prst", 32'(prng_rst), 32'd1);

        start = 1'b1; seed_in = 5'($urandom);
        cyc();
        start = 1'b0;
        for (int i = 0; i < 1500; i++) begin
            bus.req = N'($urandom);
            reseed  = ($urandom_range(0, 15) == 0);
            start   = ($urandom_range(0, 39) == 0);
            seed_in = 5'($urandom);
            if ($urandom_range(0, 299) == 0) begin
                #1 rst = 1'b0;
                #1 rst = 1'b1;
            end
            cyc();
        end
        bus.req = '0; reseed = 1'b0; start = 1'b0;
        repeat (4) cyc();

        $display("Simulation finished: %0d checks, %0d errors",
                 checks, errors);
        $finish;
    end
endmodule
